// File: rtl/slot_tracker_pkg.sv
// Shared constants and helpers for the slot tracker.
// The index width reserves its all-ones pattern as the "no slot" marker.
package slot_tracker_pkg;

    localparam logic [31:0] NO_SLOT_ALL = '1;

    function automatic int idx_width(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/dual_zero_find.sv
// Finds the lowest and second-lowest clear bit of an occupancy vector.
// Walks the vector LSB-first; missing results read as all-ones.
module dual_zero_find
    import slot_tracker_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int IDXW = idx_width(SIZE)
) (
    input  logic [SIZE-1:0] busy,
    output logic [IDXW-1:0] idx0,
    output logic [IDXW-1:0] idx1
);

    localparam logic [IDXW-1:0] NO_SLOT = NO_SLOT_ALL[IDXW-1:0];

    logic found0;
    logic found1;

    always_comb begin
        idx0   = NO_SLOT;
        idx1   = NO_SLOT;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (!busy[i]) begin
                if (!found0) begin
                    idx0   = IDXW'(i);
                    found0 = 1'b1;
                end else if (!found1) begin
                    idx1   = IDXW'(i);
                    found1 = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/slot_tracker.sv
// Two-wide slot allocator/releaser with registered occupancy and free count.
// Optional protocol checking on releases is enabled with SLOT_TRACKER_CHECK_EN.
module slot_tracker
    import slot_tracker_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int IDXW = idx_width(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [1:0]      alloc_num,
    output logic [1:0]      alloc_gnt,
    output logic [IDXW-1:0] alloc_idx0,
    output logic [IDXW-1:0] alloc_idx1,
    input  logic [1:0]      rel_valid,
    input  logic [IDXW-1:0] rel_idx0,
    input  logic [IDXW-1:0] rel_idx1,
    output logic [SIZE-1:0] busy,
    output logic [IDXW-1:0] free_count,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam logic [IDXW-1:0] NO_SLOT  = NO_SLOT_ALL[IDXW-1:0];
    localparam logic [SIZE-1:0] ONE      = SIZE'(1);
    localparam logic [IDXW-1:0] SIZE_CNT = IDXW'(SIZE);

    logic [SIZE-1:0] rel_mask0;
    logic [SIZE-1:0] rel_mask1;
    logic [SIZE-1:0] rel_eff;
    logic [SIZE-1:0] gnt_mask;
    logic [SIZE-1:0] busy_nxt;
    logic            rel_hit0;
    logic            rel_hit1;
    logic [IDXW-1:0] free_nxt;

    // Candidates come from registered busy only, so a release never feeds an alloc in the same cycle.
    dual_zero_find #(
        .SIZE (SIZE),
        .IDXW (IDXW)
    ) u_find (
        .busy (busy),
        .idx0 (alloc_idx0),
        .idx1 (alloc_idx1)
    );

    assign alloc_gnt[0] = (alloc_num != 2'd0) && (alloc_idx0 != NO_SLOT);
    assign alloc_gnt[1] = alloc_num[1] && (alloc_idx1 != NO_SLOT);

    // Out-of-range indices shift the one-hot off the end and yield an empty mask.
    always_comb begin
        rel_mask0 = rel_valid[0] ? (ONE << rel_idx0) : '0;
        rel_mask1 = rel_valid[1] ? (ONE << rel_idx1) : '0;
        rel_eff   = (rel_mask0 | rel_mask1) & busy;
        rel_hit0  = |(rel_mask0 & busy);
        rel_hit1  = |(rel_mask1 & busy & ~rel_mask0);
        gnt_mask  = (alloc_gnt[0] ? (ONE << alloc_idx0) : '0)
                  | (alloc_gnt[1] ? (ONE << alloc_idx1) : '0);
        busy_nxt  = (busy & ~rel_eff) | gnt_mask;
        free_nxt  = free_count + IDXW'(rel_hit0) + IDXW'(rel_hit1)
                  - IDXW'(alloc_gnt[0]) - IDXW'(alloc_gnt[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            free_count <= SIZE_CNT;
        end else if (flush) begin
            busy       <= '0;
            free_count <= SIZE_CNT;
        end else begin
            busy       <= busy_nxt;
            free_count <= free_nxt;
        end
    end

    assign full  = (free_count == '0);
    assign empty = (free_count == SIZE_CNT);

`ifdef SLOT_TRACKER_CHECK_EN
    logic bad0;
    logic bad1;
    logic dup;

    assign bad0 = rel_valid[0] && !(|(rel_mask0 & busy));
    assign bad1 = rel_valid[1] && !(|(rel_mask1 & busy));
    assign dup  = (&rel_valid) && (rel_idx0 == rel_idx1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad0 || bad1 || dup) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_slot_tracker.sv
// Bench for slot_tracker: directed scenarios then randomized traffic against a slot-list model.
module tb_slot_tracker;

    localparam int SIZE = 16;
    localparam int IDXW = 5;
    localparam int NONE = 31;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      alloc_num;
    logic [1:0]      alloc_gnt;
    logic [IDXW-1:0] alloc_idx0;
    logic [IDXW-1:0] alloc_idx1;
    logic [1:0]      rel_valid;
    logic [IDXW-1:0] rel_idx0;
    logic [IDXW-1:0] rel_idx1;
    logic [SIZE-1:0] busy;
    logic [IDXW-1:0] free_count;
    logic            full;
    logic            empty;
    logic            err;

    int n_checks = 0;
    int n_errs   = 0;

    bit mbusy[SIZE];
    bit merr;

    slot_tracker #(.SIZE(SIZE), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc_num  (alloc_num),
        .alloc_gnt  (alloc_gnt),
        .alloc_idx0 (alloc_idx0),
        .alloc_idx1 (alloc_idx1),
        .rel_valid  (rel_valid),
        .rel_idx0   (rel_idx0),
        .rel_idx1   (rel_idx1),
        .busy       (busy),
        .free_count (free_count),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < SIZE; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic int model_free();
        int c = 0;
        for (int i = 0; i < SIZE; i++) if (!mbusy[i]) c++;
        return c;
    endfunction

    task automatic model_find(output int f0, output int f1);
        int freeq[$];
        for (int i = 0; i < SIZE; i++) if (!mbusy[i]) freeq.push_back(i);
        f0 = (freeq.size() > 0) ? freeq[0] : NONE;
        f1 = (freeq.size() > 1) ? freeq[1] : NONE;
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) mbusy[i] = 1'b0;
        merr = 1'b0;
    endtask

    task automatic check_outputs();
        int f0, f1, n;
        logic [1:0] eg;
        model_find(f0, f1);
        n = (alloc_num == 2'd3) ? 2 : int'(alloc_num);
        eg[0] = (n >= 1) && (f0 != NONE);
        eg[1] = (n >= 2) && (f1 != NONE);
        check("idx0", 32'(alloc_idx0), f0);
        check("idx1", 32'(alloc_idx1), f1);
        check("gnt", 32'(alloc_gnt), 32'(eg));
        check("busy", 32'(busy), model_vec());
        check("free_count", 32'(free_count), model_free());
        check("full", 32'(full), (model_free() == 0) ? 1 : 0);
        check("empty", 32'(empty), (model_free() == SIZE) ? 1 : 0);
        check("err", 32'(err), 32'(merr));
    endtask

    task automatic model_step(input bit fl, input int num, input logic [1:0] rv, input int i0, input int i1);
        bit nb[SIZE];
        bit bad = 1'b0;
        int f0, f1, n, idx;
        nb = mbusy;
        n = (num >= 2) ? 2 : num;
        model_find(f0, f1);
        for (int k = 0; k < 2; k++) begin
            if (rv[k]) begin
                idx = (k == 0) ? i0 : i1;
                if (idx >= SIZE) bad = 1'b1;
                else if (!mbusy[idx]) bad = 1'b1;
                else nb[idx] = 1'b0;
            end
        end
        if (rv == 2'b11 && i0 == i1) bad = 1'b1;
        if (n >= 1 && f0 != NONE) nb[f0] = 1'b1;
        if (n >= 2 && f1 != NONE) nb[f1] = 1'b1;
        if (fl) for (int i = 0; i < SIZE; i++) nb[i] = 1'b0;
        mbusy = nb;
`ifdef SLOT_TRACKER_CHECK_EN
        if (bad) merr = 1'b1;
`else
        if (bad) merr = merr;
`endif
    endtask

    // One clock: drive, check at the falling edge, advance the model, release reset after the edge.
    task automatic cycle(input bit r, input bit fl, input int num, input logic [1:0] rv,
                         input int i0, input int i1);
        flush     = fl;
        alloc_num = num[1:0];
        rel_valid = rv;
        rel_idx0  = i0[IDXW-1:0];
        rel_idx1  = i1[IDXW-1:0];
        if (r) begin
            rst = 1'b1;
            model_reset();
            #1;
            check("rst_busy", 32'(busy), 0);
            check("rst_free", 32'(free_count), SIZE);
            check("rst_err", 32'(err), 0);
        end
        @(negedge clk);
        check_outputs();
        if (!r) model_step(fl, num, rv, i0, i1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int num, i0, i1;
        logic [1:0] rv;
        bit r, fl;
        rst = 1'b0; flush = 1'b0; alloc_num = '0; rel_valid = '0; rel_idx0 = '0; rel_idx1 = '0;
        model_reset();
        #2;
        cycle(1, 0, 0, 2'b00, 0, 0);
        check("reset_idx0", 32'(alloc_idx0), 0);
        check("reset_idx1", 32'(alloc_idx1), 1);
        check("reset_empty", 32'(empty), 1);

        cycle(0, 0, 2, 2'b00, 0, 0);
        check("first_busy", 32'(busy), 32'h0003);
        check("first_free", 32'(free_count), SIZE - 2);

        for (int k = 0; k < 7; k++) cycle(0, 0, 2, 2'b00, 0, 0);
        check("fill_full", 32'(full), 1);
        check("fill_idx0", 32'(alloc_idx0), NONE);
        check("fill_idx1", 32'(alloc_idx1), NONE);
        check("fill_gnt", 32'(alloc_gnt), 0);
        cycle(0, 0, 2, 2'b00, 0, 0);

        cycle(0, 0, 0, 2'b01, 9, 0);
        alloc_num = 2'd2;
        #1;
        check("partial_gnt", 32'(alloc_gnt), 32'h1);
        check("partial_idx0", 32'(alloc_idx0), 9);
        check("partial_idx1", 32'(alloc_idx1), NONE);
        cycle(0, 0, 2, 2'b00, 0, 0);
        check("partial_full", 32'(full), 1);

        alloc_num = 2'd1; rel_valid = 2'b11; rel_idx0 = 5'd3; rel_idx1 = 5'd12;
        #1;
        check("relalloc_gnt", 32'(alloc_gnt), 0);
        cycle(0, 0, 1, 2'b11, 3, 12);
        check("relalloc_idx0", 32'(alloc_idx0), 3);
        check("relalloc_idx1", 32'(alloc_idx1), 12);
        check("relalloc_free", 32'(free_count), 2);

        cycle(0, 0, 0, 2'b01, 3, 0);
        check("free_rel_count", 32'(free_count), 2);
        cycle(0, 0, 0, 2'b10, 0, NONE);
        check("oor_rel_count", 32'(free_count), 2);
        cycle(0, 0, 0, 2'b11, 4, 4);
        check("dup_rel_count", 32'(free_count), 3);
        cycle(0, 0, 0, 2'b00, 0, 0);

        cycle(1, 0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2, 2'b00, 0, 0);
        cycle(0, 1, 2, 2'b01, 1, 0);
        check("flush_busy", 32'(busy), 0);
        check("flush_free", 32'(free_count), SIZE);
        check("flush_empty", 32'(empty), 1);

        for (int k = 0; k < 600; k++) begin
            r   = ($urandom_range(0, 63) == 0);
            fl  = ($urandom_range(0, 40) == 0);
            num = (k % 200 < 120) ? $urandom_range(1, 3) : $urandom_range(0, 1);
            rv  = 2'($urandom_range(0, 3));
            i0  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, SIZE - 1);
            i1  = ($urandom_range(0, 7) == 0) ? i0 : $urandom_range(0, SIZE - 1);
            if (k % 200 >= 120 && rv == 2'b00) rv = 2'b01;
            cycle(r, fl, num, rv, i0, i1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/slot_tracker.md
SLOT_TRACKER -- requirements
Module: slot_tracker

Interface
REQ-001 Parameter SIZE, default 16: number of tracked slots, SIZE >= 2.
REQ-002 Parameter IDXW, default $clog2(SIZE)+1: index width; all-ones (-1) encodes "no slot".
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous clear of all busy slots.
REQ-006 alloc_num  input  2  slots requested this cycle: 0, 1 or 2; value 3 treated as 2.
REQ-007 alloc_gnt  output  2  bit0: alloc_idx0 granted; bit1: alloc_idx1 granted.
REQ-008 alloc_idx0  output  IDXW  lowest free slot index, -1 if none.
REQ-009 alloc_idx1  output  IDXW  second-lowest free slot index, -1 if fewer than two free.
REQ-010 rel_valid  input  2  bit n qualifies rel_idxn.
REQ-011 rel_idx0, rel_idx1  input  IDXW each  slots returned this cycle.
REQ-012 busy  output  SIZE  registered occupancy vector, 1 = allocated.
REQ-013 free_count  output  IDXW  registered count of zero bits in busy.
REQ-014 full  output  1  free_count == 0; empty  output  1  free_count == SIZE.
REQ-015 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-016 alloc_idx0/alloc_idx1 SHALL be combinational from registered busy only (never from same-cycle releases).
REQ-017 alloc_gnt[0] SHALL = (alloc_num >= 1) && alloc_idx0 != -1; alloc_gnt[1] SHALL = (alloc_num >= 2) && alloc_idx1 != -1.
REQ-018 With one free slot and alloc_num = 2, only alloc_gnt[0] SHALL assert (partial grant).
REQ-019 Granted slots SHALL read busy = 1 from the next edge (latency 1).
REQ-020 A valid release of an in-range busy slot SHALL clear its busy bit at the next edge; the slot is allocatable no earlier than the following cycle (no release-to-alloc bypass).
REQ-021 Release of a free slot, or index >= SIZE (including -1), SHALL leave busy and free_count unchanged.
REQ-022 rel_idx0 == rel_idx1 with both valid SHALL count as one release.
REQ-023 Allocation and release in the same cycle SHALL both take effect; free_count(next) = free_count + effective releases - grants.
REQ-024 flush SHALL override alloc and release: next busy = 0, free_count = SIZE; alloc_gnt still reflects current state but grants are discarded.
REQ-025 free_count SHALL always equal popcount(~busy); full/empty derived combinationally from free_count.

Reset
REQ-026 rst high SHALL immediately force busy = 0, free_count = SIZE, err = 0; hence empty = 1, full = 0, alloc_idx0 = 0, alloc_idx1 = 1.
REQ-027 rst asserted mid-operation SHALL discard all in-flight allocations and releases of that cycle.

Configuration
REQ-028 Macro SLOT_TRACKER_CHECK_EN defined: err SHALL set at the next edge on release of a free slot, out-of-range release, or duplicate release pair, and hold until rst.
REQ-029 Macro undefined: err SHALL be tied 0 and no checking logic SHALL be synthesized; REQ-021/REQ-022 behaviour unchanged.

Structure
REQ-030 Package slot_tracker_pkg SHALL hold the NO_SLOT all-ones constant function/localparam and the index-width helper.
REQ-031 Sub-module dual_zero_find SHALL compute the lowest and second-lowest zero index of busy via an LSB-first priority chain; slot_tracker instantiates it once.

Verification
REQ-032 Reset, alloc_num=2 -> gnt=2'b11, idx0=0, idx1=1; next cycle busy=...0011, free_count=SIZE-2.
REQ-033 Fill all 16 slots two at a time -> after 8 cycles full=1, idx0=idx1=-1, gnt=0 on any request.
REQ-034 busy = all-ones except slot 9, alloc_num=2 -> gnt=2'b01, idx0=9, idx1=-1; next cycle full=1.
REQ-035 Full, release 3 and 12 same cycle with alloc_num=1 -> no grant that cycle; next cycle idx0=3, idx1=12, free_count=2.
REQ-036 With CHECK_EN: release slot 5 while free -> err=1 next cycle, free_count unchanged, err held until rst.
REQ-037 Mid-fill flush with alloc_num=2 -> next cycle busy=0, free_count=16, empty=1.
